// File: rtl/tdc_sample_accum.sv
// tdc_sample_accum
// Windowed accumulator that sits after the TDC popcount stage. Samples are
// grouped into windows of 2^LOG2_S. For each window it produces the sum, the
// round-half-up mean, the minimum and the maximum. Results leave through a
// one-entry valid/ready register. Two sticky flags report trouble: overrun
// means a finished window was dropped, and range_err means a sample above N
// arrived.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   en                    accumulate enable; low abandons a partial window
//   clear                 clears flags and the partial window
//   in_valid, in_count    popcount sample (0..N legal)
//   out_valid, out_ready  result handshake
//   out_sum/mean/min/max  window statistics
//   overrun, range_err    sticky status flags
module tdc_sample_accum #(
    parameter int N      = 64,
    parameter int CW     = $clog2(N) + 1,
    parameter int LOG2_S = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [CW-1:0]        in_count,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW+LOG2_S-1:0] out_sum,
    output logic [CW-1:0]        out_mean,
    output logic [CW-1:0]        out_min,
    output logic [CW-1:0]        out_max,
    output logic                 overrun,
    output logic                 range_err
);

    localparam int SW   = CW + LOG2_S;
    // A zero-width counter is not legal, so LOG2_S=0 keeps one bit pinned at 0.
    localparam int CNTW = (LOG2_S > 0) ? LOG2_S : 1;
    localparam int HALF = (LOG2_S > 0) ? (1 << (LOG2_S - 1)) : 0;
    localparam logic [CNTW-1:0] LAST = CNTW'((1 << LOG2_S) - 1);
    localparam logic [CW-1:0]   NMAX = CW'(N);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t          state, state_nx;
    logic [CNTW-1:0] cnt;
    logic [SW-1:0]   sum_r;
    logic [CW-1:0]   min_r, max_r;

    logic            accept, too_big, first, complete;
    logic [CW-1:0]   sample;
    logic [SW-1:0]   sum_nx;
    logic [CW-1:0]   min_nx, max_nx, mean_nx;
    logic [SW:0]     rounded;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en)  state_nx = ACCUM;
            ACCUM:   if (!en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign accept   = en & in_valid & ~clear;
    assign too_big  = in_count > NMAX;
    assign sample   = too_big ? NMAX : in_count;
    assign first    = (state == IDLE) || (cnt == '0);
    assign complete = accept && (cnt == LAST);

    assign sum_nx  = first ? SW'(sample) : sum_r + SW'(sample);
    assign min_nx  = (first || sample < min_r) ? sample : min_r;
    assign max_nx  = (first || sample > max_r) ? sample : max_r;
    // One extra bit holds the rounding carry before the shift. The mean never
    // exceeds N, so truncating back to CW bits loses nothing.
    assign rounded = {1'b0, sum_nx} + (SW+1)'(HALF);
    assign mean_nx = CW'(rounded >> LOG2_S);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sum_r     <= '0;
            min_r     <= '0;
            max_r     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_mean  <= '0;
            out_min   <= '0;
            out_max   <= '0;
            overrun   <= 1'b0;
            range_err <= 1'b0;
        end else begin
            state <= state_nx;

            if (!en || clear) begin
                cnt <= '0;
            end else if (accept) begin
                cnt   <= (cnt == LAST) ? '0 : cnt + CNTW'(1);
                sum_r <= sum_nx;
                min_r <= min_nx;
                max_r <= max_nx;
            end

            if (clear) begin
                overrun   <= 1'b0;
                range_err <= 1'b0;
            end else begin
                if (accept && too_big)
                    range_err <= 1'b1;
                if (complete && out_valid && !out_ready)
                    overrun <= 1'b1;
            end

            if (complete && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                out_sum   <= sum_nx;
                out_mean  <= mean_nx;
                out_min   <= min_nx;
                out_max   <= max_nx;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
